// File: rtl/adc_stats_pkg.sv
// Shared types and constants for the ADC window statistics block.
//   DATA_W_DEFAULT : default ADC sample width (LTC2195 output word)
//   state_e        : window FSM states
//   acc_width()    : signed accumulator width for a given sample width and window size
package adc_stats_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    ACCUM
  } state_e;

  // Summing 2^log2_win samples of data_w bits grows the magnitude by at most log2_win bits.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned log2_win);
    return data_w + log2_win;
  endfunction

endpackage

// File: rtl/adc_window_stats_if.sv
// Sample stream in / window results out for adc_window_stats.
//   enable_in, data_valid_in, adc0_in, adc1_in, thresh_in : run control and sample pair
//   mean_out, min_out, max_out                            : {ch1, ch0} signed results
//   over_thresh_out                                       : per-channel p2p > thresh_in
//   stats_valid_out, busy_out                             : result pulse, window in progress
// master drives samples and reads results; slave is the statistics block.
interface adc_window_stats_if #(
  parameter int unsigned DATA_W = adc_stats_pkg::DATA_W_DEFAULT
);

  logic                  enable_in;
  logic                  data_valid_in;
  logic [DATA_W-1:0]     adc0_in;
  logic [DATA_W-1:0]     adc1_in;
  logic [DATA_W-1:0]     thresh_in;
  logic [2*DATA_W-1:0]   mean_out;
  logic [2*DATA_W-1:0]   min_out;
  logic [2*DATA_W-1:0]   max_out;
  logic [1:0]            over_thresh_out;
  logic                  stats_valid_out;
  logic                  busy_out;

  modport master (
    output enable_in, data_valid_in, adc0_in, adc1_in, thresh_in,
    input  mean_out, min_out, max_out, over_thresh_out, stats_valid_out, busy_out
  );

  modport slave (
    input  enable_in, data_valid_in, adc0_in, adc1_in, thresh_in,
    output mean_out, min_out, max_out, over_thresh_out, stats_valid_out, busy_out
  );

endinterface

// File: rtl/adc_ch_stats.sv
// One channel of window statistics: running sum, signed min/max, and the registered
// mean / min / max / peak-to-peak-over-threshold results.
//   clk_in, rst_in  : clock, synchronous active-low reset
//   load_in         : first sample of a window (restart sum/min/max from sample_in)
//   add_in          : fold sample_in into the running window
//   commit_in       : with add_in, this is the final sample; register results
//   sample_in       : signed ADC sample
//   thresh_in       : unsigned peak-to-peak threshold
//   mean_out, min_out, max_out, over_out : registered window results
module adc_ch_stats
  import adc_stats_pkg::*;
#(
  parameter int unsigned LOG2_WIN = 10,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     load_in,
  input  logic                     add_in,
  input  logic                     commit_in,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic        [DATA_W-1:0] thresh_in,
  output logic signed [DATA_W-1:0] mean_out,
  output logic signed [DATA_W-1:0] min_out,
  output logic signed [DATA_W-1:0] max_out,
  output logic                     over_out
);

  localparam int unsigned AccW = acc_width(DATA_W, LOG2_WIN);

  logic signed [AccW-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0] min_q, min_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic signed [AccW-1:0]   sample_ext;
  logic signed [AccW-1:0]   acc_sum;
  logic signed [DATA_W-1:0] min_upd;
  logic signed [DATA_W-1:0] max_upd;
  logic        [DATA_W:0]   p2p;

  logic signed [DATA_W-1:0] mean_q;
  logic signed [DATA_W-1:0] min_res_q;
  logic signed [DATA_W-1:0] max_res_q;
  logic                     over_q;

  always_comb begin
    sample_ext = {{LOG2_WIN{sample_in[DATA_W-1]}}, sample_in};
    acc_sum    = acc_q + sample_ext;
    min_upd    = (sample_in < min_q) ? sample_in : min_q;
    max_upd    = (sample_in > max_q) ? sample_in : max_q;
    // max >= min, so the sign-extended difference is non-negative and fits DATA_W+1 bits.
    p2p        = {max_upd[DATA_W-1], max_upd} - {min_upd[DATA_W-1], min_upd};

    acc_d = acc_q;
    min_d = min_q;
    max_d = max_q;
    if (load_in) begin
      acc_d = sample_ext;
      min_d = sample_in;
      max_d = sample_in;
    end else if (add_in) begin
      acc_d = acc_sum;
      min_d = min_upd;
      max_d = max_upd;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      acc_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      mean_q    <= '0;
      min_res_q <= '0;
      max_res_q <= '0;
      over_q    <= 1'b0;
    end else begin
      acc_q <= acc_d;
      min_q <= min_d;
      max_q <= max_d;
      if (commit_in) begin
        // Dropping the low LOG2_WIN bits is an arithmetic shift (floor toward -inf),
        // and the remaining DATA_W bits always hold the full mean.
        mean_q    <= acc_sum[AccW-1:LOG2_WIN];
        min_res_q <= min_upd;
        max_res_q <= max_upd;
        over_q    <= (p2p > {1'b0, thresh_in});
      end
    end
  end

  assign mean_out = mean_q;
  assign min_out  = min_res_q;
  assign max_out  = max_res_q;
  assign over_out = over_q;

endmodule

// File: rtl/adc_window_stats.sv
// Two-channel ADC window statistics. Collects 2^LOG2_WIN sample pairs per window and
// reports per-channel mean, min, max and peak-to-peak-over-threshold, back to back.
//   clk_in : system clock (rising edge)
//   rst_in : synchronous active-low reset
//   bus    : adc_window_stats_if slave (run control, samples in; results, pulse, busy out)
module adc_window_stats
  import adc_stats_pkg::*;
#(
  parameter int unsigned LOG2_WIN = 10,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT
) (
  input  logic                clk_in,
  input  logic                rst_in,
  adc_window_stats_if.slave   bus
);

  localparam int unsigned          CntW    = LOG2_WIN + 1;
  localparam logic [CntW-1:0]      LastCnt = CntW'((1 << LOG2_WIN) - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            stats_valid_q;

  logic load;
  logic add;
  logic last;
  logic busy;

  logic signed [DATA_W-1:0] mean0, mean1, min0, min1, max0, max1;
  logic                     over0, over1;

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= IDLE;
      count_q       <= '0;
      stats_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      stats_valid_q <= last;
    end
  end

  // Next-state logic. Dropping enable_in abandons the window even on what would have
  // been its final sample, so a completed window always continues into FIRST.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (bus.enable_in) state_d = FIRST;
      end
      FIRST: begin
        if (!bus.enable_in) begin
          state_d = IDLE;
        end else if (bus.data_valid_in) begin
          state_d = ACCUM;
          count_d = CntW'(1);
        end
      end
      ACCUM: begin
        if (!bus.enable_in) begin
          state_d = IDLE;
        end else if (bus.data_valid_in) begin
          if (count_q == LastCnt) begin
            state_d = FIRST;
            count_d = '0;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    load = 1'b0;
    add  = 1'b0;
    last = 1'b0;
    case (state_q)
      FIRST: load = bus.enable_in && bus.data_valid_in;
      ACCUM: begin
        add  = bus.enable_in && bus.data_valid_in;
        last = add && (count_q == LastCnt);
      end
      default: ;
    endcase
    busy = (state_q != IDLE);
  end

  adc_ch_stats #(
    .LOG2_WIN (LOG2_WIN),
    .DATA_W   (DATA_W)
  ) u_ch0 (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load_in   (load),
    .add_in    (add),
    .commit_in (last),
    .sample_in (bus.adc0_in),
    .thresh_in (bus.thresh_in),
    .mean_out  (mean0),
    .min_out   (min0),
    .max_out   (max0),
    .over_out  (over0)
  );

  adc_ch_stats #(
    .LOG2_WIN (LOG2_WIN),
    .DATA_W   (DATA_W)
  ) u_ch1 (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load_in   (load),
    .add_in    (add),
    .commit_in (last),
    .sample_in (bus.adc1_in),
    .thresh_in (bus.thresh_in),
    .mean_out  (mean1),
    .min_out   (min1),
    .max_out   (max1),
    .over_out  (over1)
  );

  assign bus.mean_out        = {mean1, mean0};
  assign bus.min_out         = {min1, min0};
  assign bus.max_out         = {max1, max0};
  assign bus.over_thresh_out = {over1, over0};
  assign bus.stats_valid_out = stats_valid_q;
  assign bus.busy_out        = busy;

endmodule
